// File: rtl/register_rename_mt_pkg.sv
// Shared micro-operation format: 64-bit uop with a valid bit and four 8-bit register fields.
// The low AW bits of each register field are the architectural index.
package register_rename_mt_pkg;
  localparam int UOP_W       = 64;
  localparam int UOP_VALID   = 0;
  localparam int UOP_REG_FW  = 8;
  localparam int UOP_I_DST_0 = 8;
  localparam int UOP_I_SRC_0 = 16;
  localparam int UOP_I_SRC_1 = 24;
  localparam int UOP_I_SRC_2 = 32;

  function automatic int tag_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_ARCH_REGS = 16;
  localparam int DEF_PHYS_REGS = 48;
  localparam int DEF_AW        = tag_bits(DEF_ARCH_REGS);
  localparam int DEF_PW        = tag_bits(DEF_PHYS_REGS);
endpackage

// File: rtl/register_rename_mt_free_list.sv
// Circular free list of physical tags: up to WIDTH pops from the speculative head and WIDTH pushes at the tail
// per cycle; the committed head is the flush checkpoint. Pops only read entries present before the edge.
module free_list
  import register_rename_mt_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 32,
  parameter int PW    = 6,
  parameter int BASE  = 16,
  localparam int HW   = tag_bits(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int NW   = $clog2(WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NW-1:0]            pop_cnt,
  output logic [WIDTH-1:0][PW-1:0] head_tags,
  input  logic [WIDTH-1:0]         push_valid,
  input  logic [WIDTH-1:0][PW-1:0] push_tag,
  input  logic                     flush,
  output logic [CW-1:0]            free_count
);
  logic [PW-1:0] mem [DEPTH];
  logic [HW-1:0] spec_head, commit_head, tail;
  logic [NW-1:0] push_cnt;
  logic [WIDTH-1:0][HW-1:0] push_idx;

  function automatic logic [HW-1:0] wrap(input logic [HW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= DEPTH) s = s - DEPTH;
    return HW'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < WIDTH; i++) head_tags[i] = mem[wrap(spec_head, i)];
  end

  // Committed pold tags are packed densely at the tail in lane order.
  always_comb begin
    push_cnt = '0;
    for (int j = 0; j < WIDTH; j++) begin
      push_idx[j] = wrap(tail, int'(push_cnt));
      if (push_valid[j]) push_cnt = push_cnt + NW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= PW'(BASE + i);
      spec_head   <= '0;
      commit_head <= '0;
      tail        <= '0;
      free_count  <= CW'(DEPTH);
    end else begin
      for (int j = 0; j < WIDTH; j++) begin
        if (push_valid[j]) mem[push_idx[j]] <= push_tag[j];
      end
      tail        <= wrap(tail, int'(push_cnt));
      commit_head <= wrap(commit_head, int'(push_cnt));
      // Every tag not held by the committed map is free again after a flush.
      if (flush) begin
        spec_head  <= wrap(commit_head, int'(push_cnt));
        free_count <= CW'(DEPTH);
      end else begin
        spec_head  <= wrap(spec_head, int'(pop_cnt));
        free_count <= free_count - CW'(pop_cnt) + CW'(push_cnt);
      end
    end
  end
endmodule

// File: rtl/register_rename_mt.sv
// Renames a group of WIDTH uops per cycle with intra-group bypass; outputs registered 1 cycle after accept,
// held while out_ready is low; in_ready drops when stalled, flushing, or fewer than WIDTH free tags.
module register_rename_mt
  import register_rename_mt_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int ARCH_REGS = 16,
  parameter int PHYS_REGS = 48,
  localparam int AW       = tag_bits(ARCH_REGS),
  localparam int PW       = tag_bits(PHYS_REGS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0][UOP_W-1:0] uops_i,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0][UOP_W-1:0] uops_o,
  output logic [WIDTH-1:0][PW-1:0]    pdst_o,
  output logic [WIDTH-1:0][PW-1:0]    psrc0_o,
  output logic [WIDTH-1:0][PW-1:0]    psrc1_o,
  output logic [WIDTH-1:0][PW-1:0]    psrc2_o,
  output logic [WIDTH-1:0][PW-1:0]    pold_o,
  input  logic [WIDTH-1:0]            commit_valid,
  input  logic [WIDTH-1:0][AW-1:0]    commit_arch,
  input  logic [WIDTH-1:0][PW-1:0]    commit_pdst,
  input  logic [WIDTH-1:0][PW-1:0]    commit_pold,
  input  logic                        flush
);
  localparam int DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int FCW   = $clog2(DEPTH + 1);
  localparam int NW    = $clog2(WIDTH + 1);

  logic [PW-1:0] srat [ARCH_REGS];
  logic [PW-1:0] crat [ARCH_REGS];
  logic [PW-1:0] crat_nxt [ARCH_REGS];

  logic [WIDTH-1:0]         act;
  logic [WIDTH-1:0][AW-1:0] dst, s0, s1, s2;
  logic [WIDTH-1:0][PW-1:0] head_tags, new_tag, b_s0, b_s1, b_s2, b_old;
  logic [NW-1:0]            pop_cnt, fl_pop;
  logic [FCW-1:0]           free_count;
  logic                     accept;

  assign in_ready = !flush && (!out_valid || out_ready) && (free_count >= FCW'(WIDTH));
  assign accept   = in_valid && in_ready && !rst;
  assign fl_pop   = accept ? pop_cnt : '0;

  free_list #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW), .BASE(ARCH_REGS)) u_free_list (
    .clk        (clk),
    .rst        (rst),
    .pop_cnt    (fl_pop),
    .head_tags  (head_tags),
    .push_valid (commit_valid),
    .push_tag   (commit_pold),
    .flush      (flush),
    .free_count (free_count)
  );

  // Active lanes take consecutive head entries; inactive lanes skip without consuming.
  always_comb begin
    pop_cnt = '0;
    for (int k = 0; k < WIDTH; k++) begin
      act[k]     = in_valid && uops_i[k][UOP_VALID];
      dst[k]     = uops_i[k][UOP_I_DST_0 +: AW];
      s0[k]      = uops_i[k][UOP_I_SRC_0 +: AW];
      s1[k]      = uops_i[k][UOP_I_SRC_1 +: AW];
      s2[k]      = uops_i[k][UOP_I_SRC_2 +: AW];
      new_tag[k] = head_tags[pop_cnt];
      if (act[k]) pop_cnt = pop_cnt + NW'(1);
    end
  end

  // Ascending j scan leaves the youngest older writer in effect.
  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      b_s0[k]  = srat[s0[k]];
      b_s1[k]  = srat[s1[k]];
      b_s2[k]  = srat[s2[k]];
      b_old[k] = srat[dst[k]];
      for (int j = 0; j < WIDTH; j++) begin
        if (j < k && act[j]) begin
          if (dst[j] == s0[k])  b_s0[k]  = new_tag[j];
          if (dst[j] == s1[k])  b_s1[k]  = new_tag[j];
          if (dst[j] == s2[k])  b_s2[k]  = new_tag[j];
          if (dst[j] == dst[k]) b_old[k] = new_tag[j];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ARCH_REGS; i++) crat_nxt[i] = crat[i];
    for (int j = 0; j < WIDTH; j++) begin
      if (commit_valid[j]) crat_nxt[commit_arch[j]] = commit_pdst[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        srat[i] <= PW'(i);
        crat[i] <= PW'(i);
      end
      out_valid <= 1'b0;
      uops_o    <= '0;
      pdst_o    <= '0;
      psrc0_o   <= '0;
      psrc1_o   <= '0;
      psrc2_o   <= '0;
      pold_o    <= '0;
    end else begin
      for (int i = 0; i < ARCH_REGS; i++) crat[i] <= crat_nxt[i];
      if (flush) begin
        for (int i = 0; i < ARCH_REGS; i++) srat[i] <= crat_nxt[i];
      end else if (accept) begin
        for (int k = 0; k < WIDTH; k++) begin
          if (act[k]) srat[dst[k]] <= new_tag[k];
        end
      end

      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        for (int k = 0; k < WIDTH; k++) begin
          uops_o[k]  <= act[k] ? uops_i[k] : '0;
          pdst_o[k]  <= act[k] ? new_tag[k] : '0;
          psrc0_o[k] <= act[k] ? b_s0[k] : '0;
          psrc1_o[k] <= act[k] ? b_s1[k] : '0;
          psrc2_o[k] <= act[k] ? b_s2[k] : '0;
          pold_o[k]  <= act[k] ? b_old[k] : '0;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/register_rename_mt.md
REGISTER_RENAME_MT -- requirements
Module: register_rename_mt

Interface
REQ-001 SHALL have parameter WIDTH, default 3, meaning uop lanes per group.
REQ-002 SHALL have parameter ARCH_REGS, default 16, meaning architectural registers (AW = $clog2(ARCH_REGS), 4 at default).
REQ-003 SHALL have parameter PHYS_REGS, default 48, meaning physical registers (PW = $clog2(PHYS_REGS)); PHYS_REGS > ARCH_REGS + WIDTH.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-006 SHALL have ports in_valid/in_ready  input/output  1/1  meaning group handshake; accept when both high.
REQ-007 SHALL have port uops_i  input  [WIDTH][64]  meaning uops in shared micro_operations format; lane 0 is oldest.
REQ-008 SHALL have ports out_valid/out_ready  output/input  1/1  meaning output handshake.
REQ-009 SHALL have port uops_o  output  [WIDTH][64]  meaning registered copy of the accepted uops.
REQ-010 SHALL have ports pdst_o, psrc0_o, psrc1_o, psrc2_o, pold_o  output  [WIDTH][PW] each  meaning the new dst tag, the src tags and the previous dst mapping.
REQ-011 SHALL have ports commit_valid  input  [WIDTH]; commit_arch  input  [WIDTH][AW]; commit_pdst, commit_pold  input  [WIDTH][PW] each  meaning in-order retirement.
REQ-012 SHALL have port flush  input  1  meaning discard all uncommitted renames.

Function
REQ-013 SHALL treat a lane as active when in_valid is high and the lane's UOP_VALID bit is set; each active lane allocates exactly one physical tag for UOP_I_DST_0.
REQ-014 SHALL drive in_ready = !flush && (!out_valid || out_ready) && free_count >= WIDTH.
REQ-015 SHALL produce registered outputs 1 cycle after acceptance; inactive lanes output all-zero uop and tags.
REQ-016 SHALL hold out_valid and all outputs stable while out_valid && !out_ready.
REQ-017 SHALL clear out_valid after a handshake if no new group is accepted in the same cycle.
REQ-018 SHALL pop tags from the free list in lane order; the lowest active lane takes the head.
REQ-019 SHALL bypass within a group: any src of lane k equal to the dst of an active lane j<k takes the new tag of the highest such j; otherwise it reads the speculative RAT (SRAT).
REQ-020 SHALL apply the same bypass to pold_o; SRAT update on multiple writes to one arch reg keeps the highest lane.
REQ-021 SHALL update the committed RAT (CRAT) for each commit lane: CRAT[commit_arch] <= commit_pdst, with the highest lane winning on conflict.
REQ-022 SHALL push each committed commit_pold to the free list tail in lane order, and advance the committed head by the commit count.
REQ-023 SHALL compute in_ready from the pre-edge free_count; tags freed in cycle N SHALL become allocatable at N+1.
REQ-024 SHALL implement the free list as a circular buffer of PHYS_REGS-ARCH_REGS entries with spec head, committed head and tail pointers that wrap modulo the depth.
REQ-025 SHALL, on flush: set SRAT <= CRAT including same-cycle commits, set spec head <= committed head after same-cycle commits, clear out_valid, and accept no group.
REQ-026 SHALL never overflow or underflow the free list under legal commit traffic (one free per committed allocation).

Reset
REQ-027 SHALL, on rst: set SRAT[i] = CRAT[i] = i; fill free-list entries with ARCH_REGS..PHYS_REGS-1; set all pointers to 0 and free_count to PHYS_REGS-ARCH_REGS; set out_valid 0 and all outputs 0.
REQ-028 SHALL give rst priority over flush, commit and accept, including mid-group.

Structure
REQ-029 SHALL place UOP field bit positions and the PW/AW helper constants in the shared micro_operations package.
REQ-030 SHALL factor the free list into the sub-module free_list (multi-push/multi-pop, checkpointed head).

Verification
REQ-031 SHALL cover: after reset, lanes dst r1,r2,r3 -> pdst 16,17,18, pold 1,2,3, out_valid at +1 cycle.
REQ-032 SHALL cover: lane0 dst r5; lane1 src0 r5, dst r5; lane2 src1 r5 -> lane1 psrc0 16, pold 16; lane2 psrc1 17.
REQ-033 SHALL cover: 10 full groups with no commits -> free_count 2, in_ready 0; one commit of 3 pold tags -> in_ready 1 on the following cycle.
REQ-034 SHALL cover: rename r1 to 16, flush without commit -> the next group reads r1 as 1 and allocates 16 again.
REQ-035 SHALL cover: out_ready held low for 4 cycles -> outputs stable and in_ready 0; flush in the same cycle as a commit of r2 to 20 -> a subsequent src r2 reads 20.
REQ-036 SHALL cover: rst asserted mid-stream -> next cycle out_valid 0 and the reset-state mapping of REQ-031 recurs.
